// File: rtl/FPU_pkg.sv
// Shared FPU constants and types: FCLASS bit indices, exponent constants and
// the unpacked-operand record used by the input stage.
package FPU_pkg;

    localparam int FPU_FLOAT_W = 32;
    localparam int FPU_MAN_W   = 24;
    localparam int FPU_EXP_W   = 10;

    localparam int FPU_CLASS_NINF = 0;
    localparam int FPU_CLASS_NNORM = 1;
    localparam int FPU_CLASS_NSUB = 2;
    localparam int FPU_CLASS_NZERO = 3;
    localparam int FPU_CLASS_PZERO = 4;
    localparam int FPU_CLASS_PSUB = 5;
    localparam int FPU_CLASS_PNORM = 6;
    localparam int FPU_CLASS_PINF = 7;
    localparam int FPU_CLASS_SNAN = 8;
    localparam int FPU_CLASS_QNAN = 9;

    // Exponents are 10-bit two's complement values.
    localparam logic [FPU_EXP_W-1:0] FPU_BIAS       = 10'd127;
    localparam logic [FPU_EXP_W-1:0] FPU_EXP_INF    = 10'd128;
    localparam logic [FPU_EXP_W-1:0] FPU_EXP_ZERO   = 10'h381;  // -127
    localparam logic [FPU_EXP_W-1:0] FPU_EXP_DENORM = 10'h382;  // -126

    typedef struct packed {
        logic                 sgn;
        logic [FPU_EXP_W-1:0] exp;
        logic [FPU_MAN_W-1:0] man;
        logic [9:0]           cls;
    } operand_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] rm;
        operand_t   a;
        operand_t   b;
    } stage_t;

    function automatic logic [9:0] class_mask(input int idx);
        return 10'(1) << idx;
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count; an all-zero input reports WIDTH.
module leading_zero_counter #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o
);

    // NOTE: the default assignment before the loop keeps this block free of inferred latches.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        // Scanning upward, the last hit is the most significant set bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/pre_processor.sv
// FPU input stage: unpacks two binary32 operands into sign / signed exponent /
// normalized mantissa / FCLASS mask and registers them behind a valid/ready handshake.
module pre_processor
    import FPU_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [2:0]  rm,
    input  logic [31:0] float_a,
    input  logic [31:0] float_b,
    output logic [2:0]  rm_out,
    output logic [23:0] man_a,
    output logic [23:0] man_b,
    output logic [9:0]  exp_a,
    output logic [9:0]  exp_b,
    output logic        sgn_a,
    output logic        sgn_b,
    output logic [9:0]  class_a,
    output logic [9:0]  class_b
);

    logic [4:0] lz_a;
    logic [4:0] lz_b;
    operand_t   op_a;
    operand_t   op_b;
    stage_t     stage_d;
    stage_t     stage_q;

    leading_zero_counter #(.WIDTH(24)) u_lzc_a (
        .data_i  ({1'b0, float_a[22:0]}),
        .count_o (lz_a)
    );

    leading_zero_counter #(.WIDTH(24)) u_lzc_b (
        .data_i  ({1'b0, float_b[22:0]}),
        .count_o (lz_b)
    );

    function automatic operand_t unpack_float(input logic [31:0] f, input logic [4:0] lz);
        operand_t   op;
        logic [7:0]  e;
        logic [22:0] fr;
        e      = f[30:23];
        fr     = f[22:0];
        op     = '0;
        op.sgn = f[31];
        if (e == 8'hFF) begin
            op.man = {1'b1, fr};
            op.exp = FPU_EXP_INF;
            if (fr == '0) op.cls = class_mask(f[31] ? FPU_CLASS_NINF : FPU_CLASS_PINF);
            else          op.cls = class_mask(fr[22] ? FPU_CLASS_QNAN : FPU_CLASS_SNAN);
        end else if (e == 8'h00) begin
            if (fr == '0) begin
                op.exp = FPU_EXP_ZERO;
                op.cls = class_mask(f[31] ? FPU_CLASS_NZERO : FPU_CLASS_PZERO);
            end else begin
                // Shift the subnormal until its leading one lands on the hidden-bit position.
                op.man = {1'b0, fr} << lz;
                op.exp = FPU_EXP_DENORM - {5'b0, lz};
                op.cls = class_mask(f[31] ? FPU_CLASS_NSUB : FPU_CLASS_PSUB);
            end
        end else begin
            op.man = {1'b1, fr};
            op.exp = {2'b0, e} - FPU_BIAS;
            op.cls = class_mask(f[31] ? FPU_CLASS_NNORM : FPU_CLASS_PNORM);
        end
        return op;
    endfunction

    assign op_a = unpack_float(float_a, lz_a);
    assign op_b = unpack_float(float_b, lz_b);

    assign ready_out = ready_in;

    // Flush wins over capture; a drain with no new capture empties the stage.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (valid_in && ready_out) begin
            stage_d.valid = 1'b1;
            stage_d.rm    = rm;
            stage_d.a     = op_a;
            stage_d.b     = op_b;
        end else if (stage_q.valid && ready_in) begin
            stage_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_out = stage_q.valid && !flush;
    assign rm_out    = stage_q.rm;
    assign sgn_a     = stage_q.a.sgn;
    assign exp_a     = stage_q.a.exp;
    assign man_a     = stage_q.a.man;
    assign class_a   = stage_q.a.cls;
    assign sgn_b     = stage_q.b.sgn;
    assign exp_b     = stage_q.b.exp;
    assign man_b     = stage_q.b.man;
    assign class_b   = stage_q.b.cls;

endmodule
